// File: rtl/pc_unit.sv
// Program counter with exception/stall/return/jump/branch priority and an optional return-address stack.
// Latency: one edge from request to pc_out. Backpressure: stall holds all state; only exc overrides it.
// Build with macro PC_RAS_EN for the circular RAS; without it ret loads jmp_target and call is ignored.
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 'h80,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              exc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              redirect,
    output logic              ras_empty,
    output logic              ras_full
);

    localparam logic [ADDR_W-1:0] ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_next;
    logic              redirect_next;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_avail;
    logic              push;
    logic              pop;

    assign pc_seq = pc_out + STEP;

    always_comb begin
        pc_next       = pc_seq;
        redirect_next = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        if (exc) begin
            pc_next       = EXC_VEC;
            redirect_next = 1'b1;
        end else if (stall) begin
            pc_next       = pc_out;
        end else if (ret && (ras_avail || !RAS_EN)) begin
            pc_next       = RAS_EN ? ras_top : jmp_target;
            redirect_next = 1'b1;
            pop           = RAS_EN;
        end else if (jmp) begin
            // a simultaneous ret (empty stack) suppresses the push
            pc_next       = jmp_target;
            redirect_next = 1'b1;
            push          = RAS_EN && call && !ret;
        end else if (br_taken) begin
            pc_next       = br_target;
            redirect_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out   <= RESET_VEC & ALIGN;
            pc_valid <= 1'b0;
            redirect <= 1'b0;
        end else begin
            pc_out   <= pc_next & ALIGN;
            pc_valid <= 1'b1;
            redirect <= redirect_next;
        end
    end

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  push_ptr;
    logic [PTR_W-1:0]  pop_ptr;
    logic [PTR_W-1:0]  top_ptr_next;
    logic [CNT_W-1:0]  ras_cnt;
    logic [CNT_W-1:0]  ras_cnt_next;

    assign ras_top   = ras_mem[top_ptr];
    assign ras_avail = (ras_cnt != '0);
    assign push_ptr  = (top_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_ptr + 1'b1;
    assign pop_ptr   = (top_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : top_ptr - 1'b1;

    // when full, the push slot is the oldest entry, so it is overwritten in place
    always_comb begin
        top_ptr_next = top_ptr;
        ras_cnt_next = ras_cnt;
        if (push) begin
            top_ptr_next = push_ptr;
            if (ras_cnt != CNT_W'(RAS_DEPTH))
                ras_cnt_next = ras_cnt + 1'b1;
        end else if (pop) begin
            top_ptr_next = pop_ptr;
            ras_cnt_next = ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_ptr   <= PTR_W'(RAS_DEPTH - 1);
            ras_cnt   <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
        end else begin
            top_ptr   <= top_ptr_next;
            ras_cnt   <= ras_cnt_next;
            ras_empty <= (ras_cnt_next == '0);
            ras_full  <= (ras_cnt_next == CNT_W'(RAS_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ras_mem[push_ptr] <= pc_seq;
    end
`else
    logic                             unused_ras;
    logic [$clog2(RAS_DEPTH+1)-1:0]   unused_depth;

    assign ras_top      = '0;
    assign ras_avail    = 1'b0;
    assign ras_empty    = 1'b1;
    assign ras_full     = 1'b0;
    assign unused_ras   = ^{call, push, pop};
    assign unused_depth = '0;
`endif

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in bits (min 8).
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VEC, default 'h80, PC value loaded on exception.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (2..16).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port stall  input  1  hold PC this cycle.
REQ-008 SHALL have port exc  input  1  exception redirect request.
REQ-009 SHALL have port br_taken  input  1  conditional branch taken.
REQ-010 SHALL have port br_target  input  ADDR_W  branch destination.
REQ-011 SHALL have port jmp  input  1  unconditional jump.
REQ-012 SHALL have port jmp_target  input  ADDR_W  jump destination.
REQ-013 SHALL have port call  input  1  qualifies jmp as a call (push return address).
REQ-014 SHALL have port ret  input  1  return request.
REQ-015 SHALL have port pc_out  output  ADDR_W  registered current PC.
REQ-016 SHALL have port pc_valid  output  1  registered, PC is valid for fetch.
REQ-017 SHALL have port redirect  output  1  registered pulse, PC changed non-sequentially last edge.
REQ-018 SHALL have ports ras_empty, ras_full  output  1 each  stack status.

Function
REQ-019 SHALL select next PC by priority exc > stall > ret > jmp > br_taken > sequential, evaluated each rising edge.
REQ-020 Sequential SHALL be pc_out+4, modulo 2^ADDR_W (all-ones-minus-3 wraps to 0, no flag).
REQ-021 All loaded targets SHALL have bits [1:0] forced to 0.
REQ-022 exc SHALL load EXC_VEC even when stall is high; RAS contents unchanged.
REQ-023 stall without exc SHALL hold pc_out, RAS and redirect low; jmp/br/ret/call ignored that cycle.
REQ-024 redirect SHALL be 1 for exactly one cycle after an edge that loaded exc, ret, jmp or branch target; 0 otherwise.
REQ-025 pc_valid SHALL be 0 in reset and become 1 at the first rising edge after rst deasserts, staying 1.
REQ-026 jmp with call SHALL push pc_out+4 onto the RAS and load jmp_target; call without jmp is ignored.
REQ-027 Push when full SHALL overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_full stays 1.
REQ-028 ret when RAS non-empty SHALL load the top entry and pop it.
REQ-029 ret when RAS empty SHALL take next-lower priority source (jmp/br/sequential), no pop, redirect per that source.
REQ-030 ret and call same cycle: ret wins, no push.
REQ-031 ras_empty/ras_full SHALL be registered and reflect occupancy after the current edge.

Reset
REQ-032 rst SHALL asynchronously set pc_out=RESET_VEC, pc_valid=0, redirect=0, RAS count=0, ras_empty=1, ras_full=0.
REQ-033 rst asserted mid-operation SHALL discard pending stall/jmp/ret and RAS contents immediately.

Configuration
REQ-034 With macro PC_RAS_EN defined, RAS logic SHALL be built per REQ-026..031.
REQ-035 Without PC_RAS_EN, ret SHALL load jmp_target, call SHALL be ignored, no RAS storage, ras_empty tied 1, ras_full tied 0.

Verification
REQ-036 Reset release, ADDR_W=32, no requests, 4 edges -> pc_out 0,4,8,C,10; pc_valid 1 from edge 1; redirect 0.
REQ-037 pc_out=0x100, br_taken br_target=0x203 with stall=1 then stall=0 -> holds 0x100, then 0x200, redirect 1 one cycle.
REQ-038 pc_out=0x40, exc=1 and stall=1 and jmp=1 -> pc_out=0x80, redirect 1.
REQ-039 PC_RAS_EN, RAS_DEPTH=4: 5 calls from 0x10,0x20,0x30,0x40,0x50 then 5 rets -> returns 0x54,0x44,0x34,0x24, ras_empty 1, fifth ret sequential.
REQ-040 ADDR_W=8, pc_out=0xFC, no request -> pc_out=0x00, pc_valid stays 1.
REQ-041 rst pulsed asynchronously between edges while RAS holds 2 entries -> pc_out=RESET_VEC immediately, ras_empty=1, later ret sequential.
